// File: rtl/freefall_engine_if.sv
// Control and observation bundle between game logic and the freefall_engine.
// Master drives step/jump/load/floor; slave (the engine) returns position, velocity, state.
interface freefall_engine_if #(
  parameter int Y_W = 9,
  parameter int V_W = 12
);
  logic                  tick;
  logic                  jump;
  logic                  load;
  logic [Y_W-1:0]        y_init;
  logic signed [V_W-1:0] v_init;
  logic [Y_W-1:0]        floor_y;
  logic [Y_W-1:0]        y;
  logic signed [V_W-1:0] v;
  logic [1:0]            state;
  logic                  landed;

  modport master (
    output tick, jump, load, y_init, v_init, floor_y,
    input  y, v, state, landed
  );

  modport slave (
    input  tick, jump, load, y_init, v_init, floor_y,
    output y, v, state, landed
  );
endinterface

// File: rtl/freefall_engine.sv
// Per-character vertical kinematics: fixed-point position/velocity stepped once per frame tick.
// Optional mid-air second jump is enabled by defining FREEFALL_DOUBLE_JUMP_EN.
module freefall_engine #(
  parameter int Y_W     = 9,
  parameter int FRAC    = 4,
  parameter int V_W     = 12,
  parameter int G       = 14,
  parameter int JUMP_V  = 160,
  parameter int V_MAX   = 192,
  parameter int CEIL_Y  = 479,
  parameter int RESET_Y = 16
) (
  input  logic             clk,
  input  logic             rst,
  freefall_engine_if.slave bus
);

  localparam int PW = Y_W + FRAC;
  localparam int SW = PW + 2;

  localparam logic signed [SW-1:0] G_S        = SW'(G);
  localparam logic signed [SW-1:0] NEG_VMAX_S = SW'(-V_MAX);
  localparam logic signed [SW-1:0] CEIL_S     = SW'(CEIL_Y * (2 ** FRAC));
  localparam logic signed [SW-1:0] JUMP_S     = SW'(JUMP_V);
  localparam logic [PW-1:0]        RESET_POS  = PW'(RESET_Y * (2 ** FRAC));

  typedef enum logic [1:0] {
    GROUNDED = 2'b00,
    RISING   = 2'b01,
    FALLING  = 2'b10
  } state_t;

  state_t                stateQ, stateD;
  logic [PW-1:0]         posQ, posD;
  logic signed [V_W-1:0] vQ, vD;
  logic                  landedQ, landedD;
  logic                  jumpPrevQ;
  logic                  pendingQ, pendingD;
  logic                  airJumpOk;

`ifdef FREEFALL_DOUBLE_JUMP_EN
  logic airAvailQ, airAvailD;
  assign airJumpOk = airAvailQ;
`else
  assign airJumpOk = 1'b0;
`endif

  logic                  grounded;
  logic                  jumpEdge;
  logic                  launch;
  logic                  gravity;
  logic                  hitFloor;
  logic                  hitCeil;
  logic signed [SW-1:0]  posExt;
  logic signed [SW-1:0]  vExt;
  logic signed [SW-1:0]  vSub;
  logic signed [SW-1:0]  vGrav;
  logic signed [SW-1:0]  pGrav;
  logic signed [SW-1:0]  pJump;
  logic signed [SW-1:0]  floorExt;

  // Widen everything to SW signed bits so the gravity and jump sums can never wrap.
  assign grounded = (stateQ == GROUNDED);
  assign jumpEdge = bus.jump & ~jumpPrevQ;
  assign posExt   = {2'b00, posQ};
  assign vExt     = {{(SW-V_W){vQ[V_W-1]}}, vQ};
  assign floorExt = {2'b00, bus.floor_y, {FRAC{1'b0}}};
  assign vSub     = vExt - G_S;
  assign vGrav    = (vSub < NEG_VMAX_S) ? NEG_VMAX_S : vSub;
  assign pGrav    = posExt + vGrav;
  assign pJump    = posExt + JUMP_S;
  assign hitFloor = (pGrav <= floorExt);
  assign hitCeil  = (pGrav >= CEIL_S);

  assign launch  = bus.tick & (grounded ? (pendingQ | jumpEdge)
                                        : (airJumpOk & (pendingQ | jumpEdge)));
  assign gravity = bus.tick & ~launch & (~grounded | (bus.floor_y < posQ[PW-1:FRAC]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= GROUNDED;
      posQ      <= RESET_POS;
      vQ        <= '0;
      landedQ   <= 1'b0;
      jumpPrevQ <= 1'b0;
      pendingQ  <= 1'b0;
`ifdef FREEFALL_DOUBLE_JUMP_EN
      airAvailQ <= 1'b1;
`endif
    end else begin
      stateQ    <= stateD;
      posQ      <= posD;
      vQ        <= vD;
      landedQ   <= landedD;
      jumpPrevQ <= bus.jump;
      pendingQ  <= pendingD;
`ifdef FREEFALL_DOUBLE_JUMP_EN
      airAvailQ <= airAvailD;
`endif
    end
  end

  always_comb begin
    stateD = stateQ;
    if (bus.load) begin
      stateD = (bus.v_init > 0) ? RISING : FALLING;
    end else if (launch) begin
      stateD = RISING;
    end else if (gravity) begin
      if (hitFloor)          stateD = GROUNDED;
      else if (hitCeil)      stateD = FALLING;
      else if (vGrav > 0)    stateD = RISING;
      else                   stateD = FALLING;
    end
  end

  // Datapath and pulse outputs follow the same load > launch > gravity priority as the state.
  always_comb begin
    posD     = posQ;
    vD       = vQ;
    landedD  = 1'b0;
    pendingD = pendingQ;
`ifdef FREEFALL_DOUBLE_JUMP_EN
    airAvailD = airAvailQ;
`endif
    if (bus.load) begin
      posD     = {bus.y_init, {FRAC{1'b0}}};
      vD       = bus.v_init;
      pendingD = 1'b0;
`ifdef FREEFALL_DOUBLE_JUMP_EN
      airAvailD = 1'b1;
`endif
    end else begin
      if (launch) begin
        posD     = pJump[PW-1:0];
        vD       = V_W'(JUMP_V);
        pendingD = 1'b0;
`ifdef FREEFALL_DOUBLE_JUMP_EN
        if (!grounded) airAvailD = 1'b0;
`endif
      end else begin
        if (jumpEdge && (grounded || airJumpOk)) pendingD = 1'b1;
        if (gravity) begin
          if (hitFloor) begin
            posD    = floorExt[PW-1:0];
            vD      = '0;
            landedD = 1'b1;
`ifdef FREEFALL_DOUBLE_JUMP_EN
            airAvailD = 1'b1;
`endif
          end else if (hitCeil) begin
            posD = CEIL_S[PW-1:0];
            vD   = '0;
          end else begin
            posD = pGrav[PW-1:0];
            vD   = vGrav[V_W-1:0];
          end
        end
      end
    end
  end

  assign bus.y      = posQ[PW-1:FRAC];
  assign bus.v      = vQ;
  assign bus.state  = stateQ;
  assign bus.landed = landedQ;

endmodule

// File: tb/tb_freefall_engine.sv
// Directed self-checking bench for freefall_engine; expected values are hand-computed Q.4 kinematics.
// Airborne-jump expectations follow FREEFALL_DOUBLE_JUMP_EN when it is defined.
module tb_freefall_engine;

  localparam int Y_W = 9;
  localparam int V_W = 12;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  freefall_engine_if #(.Y_W(Y_W), .V_W(V_W)) ffIf ();

  freefall_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (ffIf)
  );

  always #5 clk = ~clk;

  // Drive one cycle of controls from a falling edge; outputs are observed at the next falling edge.
  task automatic applyStimulus(input logic t, input logic j, input logic l);
    ffIf.tick = t;
    ffIf.jump = j;
    ffIf.load = l;
    @(negedge clk);
    ffIf.tick = 1'b0;
    ffIf.load = 1'b0;
  endtask

  task automatic loadChar(input int yInit, input int vInit);
    ffIf.y_init = Y_W'(yInit);
    ffIf.v_init = V_W'(vInit);
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic checkOutput(input string name, input int yExp, input int vExp, input int sExp, input int lExp);
    checks++;
    if (int'(ffIf.y) !== yExp || int'($signed(ffIf.v)) !== vExp ||
        int'(ffIf.state) !== sExp || int'(ffIf.landed) !== lExp) begin
      errors++;
      $display("[TB] FAIL %s: actual y=%0d v=%0d state=%0d landed=%0d, required y=%0d v=%0d state=%0d landed=%0d",
               name, ffIf.y, $signed(ffIf.v), ffIf.state, ffIf.landed, yExp, vExp, sExp, lExp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ffIf.tick = 1'b0; ffIf.jump = 1'b0; ffIf.load = 1'b0;
    ffIf.y_init = '0; ffIf.v_init = '0; ffIf.floor_y = 9'd16;
    #12;
    checkOutput("reset_held", 16, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset_released", 16, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("grounded_idle_tick", 16, 0, 0, 0);
  endtask

  task automatic test_jump();
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("jump_pending_no_move", 16, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("jump_launch", 26, 160, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("jump_first_gravity", 35, 146, 1, 0);
  endtask

  task automatic test_terminal_velocity();
    ffIf.floor_y = 9'd0;
    loadChar(400, 0);
    checkOutput("tv_load", 400, 0, 2, 0);
    for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("tv_tick13", 320, -182, 2, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("tv_tick14_clamped", 308, -192, 2, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("tv_tick15_clamped", 296, -192, 2, 0);
  endtask

  task automatic test_landing();
    ffIf.floor_y = 9'd16;
    loadChar(20, -64);
    checkOutput("land_load", 20, -64, 2, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("land_pulse", 16, 0, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("land_pulse_end", 16, 0, 0, 0);
  endtask

  task automatic test_ceiling();
    ffIf.floor_y = 9'd0;
    loadChar(475, 160);
    checkOutput("ceil_load", 475, 160, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ceil_bump", 479, 0, 2, 0);
    ffIf.y_init = 9'd300;
    ffIf.v_init = 12'sd32;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("load_beats_tick", 300, 32, 1, 0);
  endtask

  task automatic test_ledge_and_air_jump();
    ffIf.floor_y = 9'd16;
    loadChar(16, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ledge_setup_grounded", 16, 0, 0, 1);
    ffIf.floor_y = 9'd8;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ledge_walk_off", 15, -14, 2, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
`ifdef FREEFALL_DOUBLE_JUMP_EN
    checkOutput("air_jump_first", 25, 160, 1, 0);
`else
    checkOutput("air_jump_discarded", 13, -28, 2, 0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
`ifdef FREEFALL_DOUBLE_JUMP_EN
    checkOutput("air_jump_second_ignored", 34, 146, 1, 0);
`else
    checkOutput("air_jump_again_discarded", 10, -42, 2, 0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_air();
    ffIf.floor_y = 9'd16;
    loadChar(100, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("midair_before_reset", 97, -28, 2, 0);
    rst = 1'b1;
    #1;
    checkOutput("midair_async_reset", 16, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("after_reset_tick", 16, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_jump();
    test_terminal_velocity();
    test_landing();
    test_ceiling();
    test_ledge_and_air_jump();
    test_reset_mid_air();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/freefall_engine.md
Name: freefall_engine

Overview:
Per-character vertical kinematics engine for the game layer; the parametrised successor to the fixed single-step free-fall block.
- Fixed-point position and velocity.
- Frame-tick stepping.
- Jump launch, floor landing, ceiling bump, terminal-velocity clamp, direct load.
- Sits between input/collision logic (`jump`, `floor_y`) and the sprite renderer (`y`).

Parameters:
- Y_W, 9, integer pixel width of position.
- FRAC, 4, fractional bits of position and velocity (Q.FRAC).
- V_W, 12, signed velocity width, including FRAC bits.
- G, 14, gravity per tick in Q.FRAC units (0.875 px/tick²).
- JUMP_V, 160, launch velocity in Q.FRAC units (10 px/tick).
- V_MAX, 192, terminal fall speed magnitude in Q.FRAC units (12 px/tick).
- CEIL_Y, 479, highest legal integer y.
- RESET_Y, 16, integer y after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- tick  in  1  frame step enable; one-cycle pulse.
- jump  in  1  jump button level; rising-edge detected internally.
- load  in  1  load strobe for `y_init`/`v_init`.
- y_init  in  Y_W  integer position to load (fraction cleared).
- v_init  in  V_W  signed Q.FRAC velocity to load.
- floor_y  in  Y_W  integer surface height under the character, from collision map.
- y  out  Y_W  integer position (upper Y_W bits of internal position).
- v  out  V_W  signed Q.FRAC velocity.
- state  out  2  00 GROUNDED, 01 RISING, 10 FALLING.
- landed  out  1  one-cycle pulse on landing.

Behaviour:
- Internal position `pos` is unsigned, Y_W+FRAC bits; y = pos[Y_W+FRAC-1:FRAC]. All next-state arithmetic is done signed, at Y_W+FRAC+2 bits, so it cannot wrap.
- Reset (async, any time, mid-jump included):
  - pos = RESET_Y<<FRAC, v = 0, state = GROUNDED, landed = 0.
  - jump-edge register and jump_pending cleared.
- All outputs are registered and update one cycle after the tick/load edge. `landed` is 0 on every cycle except its pulse.
- jump_pending:
  - Set by a rising edge of `jump`.
  - Cleared when consumed by a tick, by load, or on reset.
  - A jump edge seen while RISING or FALLING is discarded.
- Priority per cycle: rst > load > tick.
- load: pos = y_init<<FRAC, v = v_init. State = RISING if v_init > 0, else FALLING; a subsequent tick resolves landing. jump_pending is cleared.
- tick while GROUNDED:
  - If jump_pending or a same-cycle jump edge: v = JUMP_V, pos += JUMP_V, no gravity this tick, state becomes RISING.
  - Else if floor_y < y (walked off a ledge): state becomes FALLING; gravity step applied this tick.
  - Else: no change.
- tick while airborne (gravity step):
  - v_n = max(v - G, -V_MAX); p_n = pos + v_n.
  - If p_n <= floor_y<<FRAC: pos = floor_y<<FRAC, v = 0, state = GROUNDED, landed = 1 next cycle.
  - Else if p_n >= CEIL_Y<<FRAC: pos = CEIL_Y<<FRAC, v = 0, state = FALLING.
  - Else: pos = p_n, v = v_n; state = RISING if v_n > 0, else FALLING.
- Floor has priority over ceiling when both hit in one tick.
- floor_y is sampled only on ticks; it may change freely between ticks.
- tick with no floor (floor_y = 0) clamps at y = 0; pos never goes negative.

Optional Feature:
- Macro: FREEFALL_DOUBLE_JUMP_EN.
- Defined:
  - One extra jump is allowed while airborne. A jump edge while RISING/FALLING with air_jump_avail = 1 sets jump_pending.
  - The next tick applies v = JUMP_V, pos += JUMP_V, state = RISING, and clears air_jump_avail.
  - air_jump_avail is set on reset, on landing and on load.
- Undefined: airborne jump edges are discarded. No air_jump_avail register exists.

Test Plan:
1. Reset mid-air (after load y_init=100, v_init=0, two ticks) with floor_y=16 -> immediately y=16, v=0, state=00, landed=0.
2. Grounded at y=16, pulse jump, then tick -> pos=416 (y=26), v=160, state=01. Next tick -> v=146, pos=562 (y=35).
3. load y_init=400, v_init=0, floor_y=0, 14 ticks -> v=-182 after tick 13; v=-192 (clamped) after tick 14 and after every later tick until landing.
4. load y_init=20, v_init=-64, floor_y=16, tick -> y=16, v=0, state=00, landed high exactly one cycle.
5. load y_init=475, v_init=160, tick -> v_n=146, p_n=7746 >= 7664 -> y=479, v=0, state=10. Also: load and tick asserted together -> load values only, no gravity step.
6. Grounded at y=16, floor_y drops to 8, tick -> state=10, v=-14, pos=242 (y=15). With FREEFALL_DOUBLE_JUMP_EN, an airborne jump edge plus tick -> v=160, state=01; a second airborne jump is ignored.
